// File: rtl/noc_pkg.sv
// ---------------------------------------------------------------------------
// noc_pkg
// Shared constants and types for the 5-port mesh router.
//   PORT_N..PORT_L : requester / port index constants
//   NOC_FLIT_W     : flit width
//   NOC_DST_LSB/W  : location of the destination {x[1:0], y[1:0]} in a flit
//   NOC_IDX_W      : width of a port index (grant_id, round-robin pointer)
//   arbState_t     : output-register FSM state encoding
// ---------------------------------------------------------------------------
package noc_pkg;

    localparam int PORT_N = 0;
    localparam int PORT_E = 1;
    localparam int PORT_S = 2;
    localparam int PORT_W = 3;
    localparam int PORT_L = 4;

    localparam int NOC_FLIT_W  = 36;
    localparam int NOC_DST_LSB = 0;
    localparam int NOC_DST_W   = 4;

    // Three bits cover up to eight requesters; the router uses five.
    localparam int NOC_IDX_W = 3;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } arbState_t;

endpackage

// File: rtl/noc_out_arbiter_rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
// Combinational round-robin picker: starting one past ptr and wrapping
// modulo NREQ, the first asserted req bit wins.
//   req     [NREQ]      : request vector
//   ptr     [IDX_W]     : index of the most recent winner
//   gnt     [NREQ]      : one-hot winner, zero when nothing requests
//   gnt_idx [IDX_W]     : binary index of the winner (0 when no winner)
// ---------------------------------------------------------------------------
module rr_pick
    import noc_pkg::*;
#(
    parameter int NREQ = 5
) (
    input  logic [NREQ-1:0]      req,
    input  logic [NOC_IDX_W-1:0] ptr,
    output logic [NREQ-1:0]      gnt,
    output logic [NOC_IDX_W-1:0] gnt_idx
);

    logic                 w_found;
    logic [NOC_IDX_W-1:0] w_idx;

    // Walk the requesters in rotated order (ptr+1, ptr+2, ... ptr+NREQ),
    // which is the rotate / priority-encode / unrotate sequence written
    // out as a single loop; the first hit is recorded and the rest ignored.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        w_found = 1'b0;
        w_idx   = '0;
        for (int k = 1; k <= NREQ; k++) begin
            w_idx = NOC_IDX_W'((int'(ptr) + k) % NREQ);
            if (!w_found && req[w_idx]) begin
                gnt[w_idx] = 1'b1;
                gnt_idx    = w_idx;
                w_found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/noc_out_arbiter.sv
// ---------------------------------------------------------------------------
// noc_out_arbiter
// Round-robin arbiter plus one-flit output register for one router output.
//   clk, rst               : clock, asynchronous active-low reset
//   req_data  [NREQ*WIDTH] : flit of requester i in [i*WIDTH +: WIDTH]
//   req_valid [NREQ]       : requester i has a flit for this output
//   req_ready [NREQ]       : one-hot accept, combinational
//   out_data  [WIDTH]      : registered flit
//   out_valid              : out_data holds a flit
//   out_ready              : downstream accepts the flit
//   grant_id  [3]          : requester whose flit is in the register
//   perf_grants, perf_stalls [16] : saturating counters, only when the
//                            macro NOC_ARB_PERF_EN is defined
// ---------------------------------------------------------------------------
module noc_out_arbiter
    import noc_pkg::*;
#(
    parameter int WIDTH = NOC_FLIT_W,
    parameter int NREQ  = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ*WIDTH-1:0] req_data,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    output logic [WIDTH-1:0]      out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [NOC_IDX_W-1:0]  grant_id
`ifdef NOC_ARB_PERF_EN
    ,
    output logic [15:0]           perf_grants,
    output logic [15:0]           perf_stalls
`endif
);

    arbState_t            r_state;
    arbState_t            w_stateNext;
    logic [WIDTH-1:0]     r_outData;
    logic [NOC_IDX_W-1:0] r_grantId;
    logic [NOC_IDX_W-1:0] r_lastPtr;

    logic                 w_loadEn;
    logic                 w_grant;
    logic [NREQ-1:0]      w_gnt;
    logic [NOC_IDX_W-1:0] w_gntIdx;

    rr_pick #(
        .NREQ    (NREQ)
    ) u_pick (
        .req     (req_valid),
        .ptr     (r_lastPtr),
        .gnt     (w_gnt),
        .gnt_idx (w_gntIdx)
    );

    // The register can take a new flit when it is empty or when its current
    // flit leaves this cycle, which gives back-to-back transfers.
    // Accepts are gated by reset so nothing is handed out while in reset.
    assign out_valid = (r_state == FULL);
    assign w_loadEn  = (r_state == EMPTY) || (out_valid && out_ready);
    assign w_grant   = w_loadEn && (|w_gnt);
    assign req_ready = (rst && w_loadEn) ? w_gnt : '0;
    assign out_data  = r_outData;
    assign grant_id  = r_grantId;

    // Next-state logic: a grant always leaves the register full; a drain
    // without a new grant empties it; otherwise the state holds.
    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            EMPTY: if (w_grant) w_stateNext = FULL;
            FULL:  if (out_ready) w_stateNext = w_grant ? FULL : EMPTY;
            default: w_stateNext = EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= EMPTY;
        else      r_state <= w_stateNext;
    end

    // Flit, owner and round-robin pointer only move on a grant, so during
    // backpressure everything downstream-visible stays frozen. The pointer
    // starts at the last index so requester 0 has first priority.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_outData <= '0;
            r_grantId <= '0;
            r_lastPtr <= NOC_IDX_W'(NREQ - 1);
        end else if (w_grant) begin
            r_outData <= req_data[int'(w_gntIdx)*WIDTH +: WIDTH];
            r_grantId <= w_gntIdx;
            r_lastPtr <= w_gntIdx;
        end
    end

`ifdef NOC_ARB_PERF_EN
    logic [15:0] r_perfGrants;
    logic [15:0] r_perfStalls;

    // Saturating counters: they stick at all-ones instead of wrapping.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_perfGrants <= '0;
            r_perfStalls <= '0;
        end else begin
            if (w_grant && (r_perfGrants != 16'hFFFF))
                r_perfGrants <= r_perfGrants + 16'd1;
            if (out_valid && !out_ready && (r_perfStalls != 16'hFFFF))
                r_perfStalls <= r_perfStalls + 16'd1;
        end
    end

    assign perf_grants = r_perfGrants;
    assign perf_stalls = r_perfStalls;
`endif

endmodule

// File: tb/tb_noc_out_arbiter.sv
// ---------------------------------------------------------------------------
// tb_noc_out_arbiter
// Directed bench for noc_out_arbiter. Stimulus pushes the expected flit and
// owner into a queue whenever it expects a grant; a separate monitor pops
// and compares whenever the DUT hands a flit downstream.
// ---------------------------------------------------------------------------
module tb_noc_out_arbiter;

    localparam int W = 36;
    localparam int N = 5;

    typedef struct {
        logic [W-1:0] data;
        logic [2:0]   id;
    } expFlit_t;

    logic           clk;
    logic           rst;
    logic [N*W-1:0] reqData;
    logic [N-1:0]   reqValid;
    logic [N-1:0]   req_ready;
    logic [W-1:0]   out_data;
    logic           out_valid;
    logic           outReady;
    logic [2:0]     grant_id;
`ifdef NOC_ARB_PERF_EN
    logic [15:0]    perf_grants;
    logic [15:0]    perf_stalls;
`endif

    logic [W-1:0]   flit [N];
    expFlit_t       expQ [$];
    logic [W-1:0]   lastData;
    logic [2:0]     lastId;
    int             nCompared;
    int             nMismatched;

    noc_out_arbiter #(
        .WIDTH       (W),
        .NREQ        (N)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_data    (reqData),
        .req_valid   (reqValid),
        .req_ready   (req_ready),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (outReady),
        .grant_id    (grant_id)
`ifdef NOC_ARB_PERF_EN
        ,
        .perf_grants (perf_grants),
        .perf_stalls (perf_stalls)
`endif
    );

    // Free-running clock, posedge at 5, 15, 25 ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Pack the per-requester flit table onto the request bus.
    always_comb begin
        reqData = '0;
        for (int i = 0; i < N; i++) reqData[i*W +: W] = flit[i];
    end

    task automatic checkOutput(input string name, input logic [W-1:0] act,
                               input logic [W-1:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatched++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One cycle of stimulus: drive inputs just after posedge, check the
    // combinational accept and the output state mid-cycle, then record the
    // expected flit if a grant is expected.
    task automatic applyStimulus(input logic [N-1:0] v, input logic r,
                                 input logic [N-1:0] expReady, input logic expValid);
        int idx;
        idx = -1;
        reqValid = v;
        outReady = r;
        @(negedge clk);
        #1;
        checkOutput("req_ready", W'(req_ready), W'(expReady));
        checkOutput("out_valid", W'(out_valid), W'(expValid));
        if (!r && expValid) begin
            checkOutput("hold_data", out_data, lastData);
            checkOutput("hold_id", W'(grant_id), W'(lastId));
        end
        for (int i = 0; i < N; i++) if (expReady[i]) idx = i;
        if (idx >= 0) begin
            expQ.push_back('{data: flit[idx], id: 3'(idx)});
            lastData = flit[idx];
            lastId   = 3'(idx);
        end
        @(posedge clk);
        #1;
        if (idx >= 0) flit[idx] = flit[idx] + 36'h10;
    endtask

    // Asynchronous reset: outputs must clear at once and no accept may be
    // issued even with every requester valid.
    task automatic doReset();
        rst      = 1'b0;
        reqValid = '1;
        outReady = 1'b1;
        expQ.delete();
        #1;
        checkOutput("rst_out_valid", W'(out_valid), '0);
        checkOutput("rst_out_data", out_data, '0);
        checkOutput("rst_grant_id", W'(grant_id), '0);
        checkOutput("rst_req_ready", W'(req_ready), '0);
`ifdef NOC_ARB_PERF_EN
        checkOutput("rst_perf_grants", W'(perf_grants), '0);
        checkOutput("rst_perf_stalls", W'(perf_stalls), '0);
`endif
        repeat (2) @(posedge clk);
        #1;
        reqValid = '0;
        rst      = 1'b1;
    endtask

    // Scoreboard monitor: every downstream handshake must match the oldest
    // expected flit.
    initial begin
        forever begin
            @(negedge clk);
            if (rst && out_valid && outReady) begin
                if (expQ.size() == 0) begin
                    nCompared++;
                    nMismatched++;
                    $display("[TB] FAIL unexpected_flit: got %h id %0d, expected none", out_data, grant_id);
                end else begin
                    expFlit_t e;
                    e = expQ.pop_front();
                    checkOutput("out_data", out_data, e.data);
                    checkOutput("grant_id", W'(grant_id), W'(e.id));
                end
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        nCompared   = 0;
        nMismatched = 0;
        lastData    = '0;
        lastId      = '0;
        flit[0]     = 36'h000000A00;
        flit[1]     = 36'h111111B01;
        flit[2]     = 36'hABCDEF015;
        flit[3]     = 36'h333333D03;
        flit[4]     = 36'h444444E04;
        rst         = 1'b0;
        reqValid    = '0;
        outReady    = 1'b0;
        @(posedge clk);
        #1;
        doReset();

        $display("[TB] single requester");
        applyStimulus(5'b00100, 1'b1, 5'b00100, 1'b0);
        applyStimulus(5'b00000, 1'b1, 5'b00000, 1'b1);
        applyStimulus(5'b00000, 1'b1, 5'b00000, 1'b0);

        $display("[TB] full contention");
        doReset();
        applyStimulus(5'b11111, 1'b1, 5'b00001, 1'b0);
        applyStimulus(5'b11111, 1'b1, 5'b00010, 1'b1);
        applyStimulus(5'b11111, 1'b1, 5'b00100, 1'b1);
        applyStimulus(5'b11111, 1'b1, 5'b01000, 1'b1);
        applyStimulus(5'b11111, 1'b1, 5'b10000, 1'b1);
        applyStimulus(5'b11111, 1'b1, 5'b00001, 1'b1);

        $display("[TB] backpressure");
        for (int i = 0; i < 4; i++) applyStimulus(5'b01010, 1'b0, 5'b00000, 1'b1);
        applyStimulus(5'b01010, 1'b1, 5'b00010, 1'b1);
        applyStimulus(5'b01010, 1'b1, 5'b01000, 1'b1);
        applyStimulus(5'b00000, 1'b1, 5'b00000, 1'b1);
        applyStimulus(5'b00000, 1'b1, 5'b00000, 1'b0);

        $display("[TB] wrap and skip");
        applyStimulus(5'b10010, 1'b1, 5'b10000, 1'b0);
        applyStimulus(5'b10010, 1'b1, 5'b00010, 1'b1);
        applyStimulus(5'b10000, 1'b1, 5'b10000, 1'b1);
        applyStimulus(5'b10001, 1'b1, 5'b00001, 1'b1);
        applyStimulus(5'b00000, 1'b1, 5'b00000, 1'b1);
        applyStimulus(5'b00000, 1'b1, 5'b00000, 1'b0);

        $display("[TB] reset mid-stream");
        applyStimulus(5'b01100, 1'b1, 5'b00100, 1'b0);
        doReset();
        applyStimulus(5'b01110, 1'b1, 5'b00010, 1'b0);
        applyStimulus(5'b00000, 1'b1, 5'b00000, 1'b1);
        applyStimulus(5'b00000, 1'b1, 5'b00000, 1'b0);

`ifdef NOC_ARB_PERF_EN
        $display("[TB] performance counters");
        doReset();
        applyStimulus(5'b00001, 1'b1, 5'b00001, 1'b0);
        for (int i = 0; i < 9; i++) applyStimulus(5'b00001, 1'b1, 5'b00001, 1'b1);
        for (int i = 0; i < 3; i++) applyStimulus(5'b00000, 1'b0, 5'b00000, 1'b1);
        checkOutput("perf_grants", W'(perf_grants), W'(16'd10));
        checkOutput("perf_stalls", W'(perf_stalls), W'(16'd3));
        repeat (70000) @(posedge clk);
        #1;
        checkOutput("perf_stalls_sat", W'(perf_stalls), W'(16'hFFFF));
        checkOutput("perf_grants_hold", W'(perf_grants), W'(16'd10));
        applyStimulus(5'b00000, 1'b1, 5'b00000, 1'b1);
        applyStimulus(5'b00000, 1'b1, 5'b00000, 1'b0);
`endif

        checkOutput("queue_empty", W'(expQ.size()), '0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
